ff_seq_checker: RTL

Receive-side checker for the 3-bit flip-flop counter outputs Q2,Q1,Q0. It samples the counter value on qualified clock edges and acquires lock on the modulo-8 up-count sequence. Once locked, it flags every sequence break, counts errors in a saturating counter, and pulses on each 7->0 wrap. It sits beside the counter in the same clock domain as an on-board self-test monitor.

---
 rtl/ff_seq_checker.sv | 118 +++++++++++
 1 files changed

// File: rtl/ff_seq_checker.sv
`default_nettype none
// ============================================================================
// Module      : ff_seq_checker
// Description : Locks onto a 3-bit modulo-8 up-count, flags breaks, counts
//               errors (saturating) and pulses on each 7->0 wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module ff_seq_checker #(
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             EN,
    input  logic             Q2,
    input  logic             Q1,
    input  logic             Q0,
    input  logic             CLR_ERR,
    output logic             LOCKED,
    output logic             ERR,
    output logic             WRAP,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic [2:0]       EXP
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACQ    = 2'd1;
    localparam logic [1:0] c_ST_LOCKED = 2'd2;
    localparam logic [4:0] c_LOCK      = 5'(LOCK_CNT);

    logic [1:0]       r_state;
    logic [3:0]       r_run;
    logic [2:0]       r_exp;
    logic             r_locked;
    logic             r_err;
    logic             r_wrap;
    logic [ERR_W-1:0] r_err_cnt;

    logic [2:0]       w_v;
    logic [2:0]       w_next;
    logic             w_match;
    logic [4:0]       w_run_inc;
    logic             w_cnt_sat;

    assign w_v       = {Q2, Q1, Q0};
    assign w_next    = w_v + 3'd1;
    assign w_match   = (w_v == r_exp);
    assign w_run_inc = {1'b0, r_run} + 5'd1;
    assign w_cnt_sat = &r_err_cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= c_ST_IDLE;
            r_run     <= 4'd0;
            r_exp     <= 3'd0;
            r_locked  <= 1'b0;
            r_err     <= 1'b0;
            r_wrap    <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_err  <= 1'b0;
            r_wrap <= 1'b0;
            if (EN) begin
                case (r_state)
                    c_ST_IDLE: begin
                        r_exp   <= w_next;
                        r_run   <= 4'd0;
                        r_state <= c_ST_ACQ;
                    end
                    c_ST_ACQ: begin
                        r_exp <= w_next;
                        if (w_match) begin
                            r_run <= w_run_inc[3:0];
                            if (w_run_inc == c_LOCK) begin
                                r_state  <= c_ST_LOCKED;
                                r_locked <= 1'b1;
                            end
                        end else begin
                            r_run <= 4'd0;
                        end
                    end
                    c_ST_LOCKED: begin
                        r_exp <= w_next;
                        if (w_match) begin
                            r_wrap <= (w_v == 3'd0);
                        end else begin
                            // The offending value becomes the new resync point
                            r_err    <= 1'b1;
                            r_locked <= 1'b0;
                            r_run    <= 4'd0;
                            r_state  <= c_ST_ACQ;
                            if (!w_cnt_sat) begin
                                r_err_cnt <= r_err_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state  <= c_ST_IDLE;
                        r_run    <= 4'd0;
                        r_locked <= 1'b0;
                    end
                endcase
            end
            // Clear overrides any increment taken on the same edge
            if (CLR_ERR) begin
                r_err_cnt <= '0;
            end
        end
    end

    assign LOCKED  = r_locked;
    assign ERR     = r_err;
    assign WRAP    = r_wrap;
    assign ERR_CNT = r_err_cnt;
    assign EXP     = r_exp;

endmodule
`default_nettype wire
